ntsc_frame_writer: RTL
======================

# ntsc_frame_writer

Sits directly downstream of the NTSC capture stage. Accepts two-pixel 36-bit words (ntsc_pixels / ntsc_flag / frame_flag) and computes a ZBT word address for each one. Buffers the words in a small FIFO and issues them to the memory arbiter over a req/ack write port. It double-buffers whole frames in two memory banks, so the display path always reads a completed frame.

## Interface
- DEPTH, 8: FIFO entries (power of two, ≥2)
- WORDS_PER_FRAME, 153600: words per frame (640×480 pixels / 2 pixels per word)
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-low; asserted (0) clears all state on the next posedge
- capture_enable  in  1  level; request to capture frames
- ntsc_pixels  in  36  two pixels, Y/Cr/Cb/Y/Cr/Cb, stored unmodified
- ntsc_flag  in  1  one-cycle strobe; ntsc_pixels valid
- frame_flag  in  1  marks the first word of a new frame; qualified only when ntsc_flag=1 in the same cycle
- wr_req  out  1  FIFO head valid
- wr_addr  out  19  {bank, 18-bit word index}
- wr_data  out  36  FIFO head data
- wr_ack  in  1  arbiter accepts the head this cycle
- display_bank  out  1  bank holding the last completed frame
- frame_done  out  1  one-cycle pulse on a bank swap
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- capturing  out  1  state==CAPTURE

## Operation
- FSM states: IDLE, WAIT_FRAME, CAPTURE.
- IDLE → WAIT_FRAME when capture_enable=1.
- WAIT_FRAME → CAPTURE on a start word (ntsc_flag & frame_flag). The start word is written at index 0 of write_bank.
- WAIT_FRAME → IDLE if capture_enable=0.
- In CAPTURE, every ntsc_flag word is written. When a start word arrives:
  - write_bank toggles and display_bank ← old write_bank.
  - frame_done pulses and index resets to 0.
  - The start word goes to the new bank at index 0.
  - If capture_enable=0 at that cycle, the swap still happens, the start word is NOT written, and the FSM → IDLE.
- Words outside CAPTURE are ignored, except the WAIT_FRAME start word.
- Index increments after each accepted word. After index WORDS_PER_FRAME-1 it wraps to 0 in the same bank (missing frame_flag). No swap occurs on a wrap.
- Each FIFO entry holds {addr, data}, with addr computed at push time. Words still pending from the old frame keep their old-bank addresses after a swap.
- Push: a word destined for memory is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - If it is not accepted, the word is dropped, overflow←1, and index still increments so the frame geometry is preserved.
- Pop: occurs when wr_req & wr_ack. wr_ack with wr_req=0 is ignored.
- wr_req = (count≠0). wr_addr/wr_data show the head entry and are meaningful only while wr_req=1.
- overflow clears only on reset.

## Timing
- Reset values:
  - FSM=IDLE, write_bank=0, display_bank=1, index=0, count=0.
  - wr_req=0, wr_addr=0, wr_data=0 (storage cleared).
  - frame_done=0, overflow=0, capturing=0.
- Reset mid-operation: FIFO flushed, no pending write completes, FSM=IDLE.
- Latency: a word sampled at posedge N with an empty FIFO gives wr_req=1 in cycle N+1, carrying that word.
- Throughput: one push and one pop per cycle. With simultaneous push and pop, count is unchanged.
- frame_done is high for the cycle after the start word's posedge. display_bank updates on the same edge.
- capture_enable is sampled only at FSM decisions; there is no mid-frame abort.

## Test plan
- Reset, enable, three words A,B,C (no frame_flag) → none written, FSM stays WAIT_FRAME.
- Then start word S, then D, with wr_ack=1 held:
  - S is written at addr 0x00000 (bank 0, index 0), D at 0x00001.
  - wr_req rises one cycle after each strobe.
- Second start word after 5 words:
  - frame_done pulses, display_bank=0.
  - The next word goes to 0x40000 (bank 1, index 0).
  - Pending bank-0 words still drain to bank-0 addresses.
- wr_ack=0, 10 strobes with DEPTH=8:
  - count=8, overflow=1, words 9–10 dropped.
  - Releasing ack drains 8 words in 8 cycles at consecutive addrs 0–7.
  - The next accepted word is at index 10.
- FIFO full plus push and ack in the same cycle → push accepted, no overflow, count stays 8.
- WORDS_PER_FRAME=4, 6 words without frame_flag → addrs 0,1,2,3,0,1 in bank 0, no frame_done.
- capture_enable dropped mid-frame → capture continues until the next start word, which causes a swap and a frame_done pulse but is not written. FSM=IDLE, capturing=0.
- reset=0 mid-drain → next cycle wr_req=0, wr_addr=0, overflow=0, display_bank=1.

Source files
------------

// File: rtl/ntsc_frame_writer.sv
// ntsc_frame_writer_fifo: generic {addr,data} entry FIFO; write visible at head next cycle.
// Latency: 1 cycle push-to-head. One push and one pop per cycle.
// Backpressure: a push into a full FIFO is accepted only when a pop happens the same cycle; otherwise drop_o pulses.
//
// Ports: clk/reset (sync, active-low), push_i/push_dat_i, pop_i,
//        head_vld_o/head_dat_o (head entry), drop_o (push refused this cycle).
module ntsc_frame_writer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             drop_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & ~do_push;

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end
endmodule

// ntsc_frame_writer: addresses captured NTSC words into two ZBT frame banks and queues them for the arbiter.
// Latency: word strobed at posedge N appears as wr_req/wr_addr/wr_data in cycle N+1 (empty FIFO).
// Backpressure: wr_req/wr_ack handshake; a word arriving to a full FIFO without a pop is dropped and overflow sticks.
//
// Ports: clk, reset (sync, active-low), capture_enable, ntsc_pixels/ntsc_flag/frame_flag (capture input),
//        wr_req/wr_addr/wr_data/wr_ack (arbiter write port), display_bank, frame_done, overflow, capturing.
module ntsc_frame_writer #(
    parameter int DEPTH           = 8,
    parameter int WORDS_PER_FRAME = 153600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_enable,
    input  logic [35:0] ntsc_pixels,
    input  logic        ntsc_flag,
    input  logic        frame_flag,
    output logic        wr_req,
    output logic [18:0] wr_addr,
    output logic [35:0] wr_data,
    input  logic        wr_ack,
    output logic        display_bank,
    output logic        frame_done,
    output logic        overflow,
    output logic        capturing
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [35:0] data;
    } entry_t;

    localparam logic [17:0] LAST_IDX = 18'(WORDS_PER_FRAME - 1);

    state_t      state_q, state_d;
    logic        write_bank_q, write_bank_d;
    logic        display_bank_q, display_bank_d;
    logic [17:0] index_q, index_d;
    logic        frame_done_q, frame_done_d;
    logic        overflow_q, overflow_d;

    logic        start_word;
    logic        push_req;
    entry_t      push_ent;
    entry_t      head_ent;
    logic        head_vld;
    logic        pop;
    logic        drop;
    logic [17:0] index_inc;

    assign start_word = ntsc_flag & frame_flag;
    // A frame that never sees frame_flag simply wraps inside the same bank.
    assign index_inc  = (index_q == LAST_IDX) ? 18'd0 : index_q + 18'd1;
    assign pop        = head_vld & wr_ack;

    always_comb begin
        state_d        = state_q;
        write_bank_d   = write_bank_q;
        display_bank_d = display_bank_q;
        index_d        = index_q;
        frame_done_d   = 1'b0;
        push_req       = 1'b0;
        push_ent.addr  = {write_bank_q, index_q};
        push_ent.data  = ntsc_pixels;

        case (state_q)
            IDLE: begin
                index_d = 18'd0;
                if (capture_enable) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!capture_enable) begin
                    state_d = IDLE;
                end else if (start_word) begin
                    // First frame lands in the current write bank; no swap yet.
                    state_d       = CAPTURE;
                    push_req      = 1'b1;
                    push_ent.addr = {write_bank_q, 18'd0};
                    index_d       = (LAST_IDX == 18'd0) ? 18'd0 : 18'd1;
                end
            end
            CAPTURE: begin
                if (start_word) begin
                    write_bank_d   = ~write_bank_q;
                    display_bank_d = write_bank_q;
                    frame_done_d   = 1'b1;
                    if (capture_enable) begin
                        push_req      = 1'b1;
                        push_ent.addr = {~write_bank_q, 18'd0};
                        index_d       = (LAST_IDX == 18'd0) ? 18'd0 : 18'd1;
                    end else begin
                        // Capture stops on a frame boundary; the start word is discarded.
                        state_d = IDLE;
                        index_d = 18'd0;
                    end
                end else if (ntsc_flag) begin
                    push_req = 1'b1;
                    // Advance even if the FIFO drops the word so later words stay in place.
                    index_d  = index_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            write_bank_q   <= 1'b0;
            display_bank_q <= 1'b1;
            index_q        <= 18'd0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_bank_q   <= write_bank_d;
            display_bank_q <= display_bank_d;
            index_q        <= index_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
        end
    end

    ntsc_frame_writer_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_req),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_dat_o (head_ent),
        .drop_o     (drop)
    );

    assign wr_req       = head_vld;
    assign wr_addr      = head_ent.addr;
    assign wr_data      = head_ent.data;
    assign display_bank = display_bank_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
    assign capturing    = (state_q == CAPTURE);
endmodule
